prog_delay_line: RTL and testbench
==================================

# prog_delay_line

- Parametrised, runtime-programmable delay buffer for streaming datapaths.
- Successor to the fixed-depth shift FIFO: same push-on-enable behaviour, generalised as follows:
  - circular storage instead of a shift chain;
  - delay selectable per configuration in the range 1..DEPTH;
  - per-entry valid tracking;
  - synchronous flush;
  - rejection of illegal configurations.
- Sits between an MMIO-configured control block and the datapath that needs aligned, delayed samples.

## Interface
Parameters:
- DEPTH, 8, maximum delay in enables; power of two, ≥2
- BITS, 64, sample width
- DEF_DELAY, DEPTH, delay loaded at reset; must satisfy 1 ≤ DEF_DELAY ≤ DEPTH

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  push strobe: writes d/d_valid and advances the line by one
- d  in  BITS  sample in
- d_valid  in  1  valid tag stored with d
- flush  in  1  clears all valid tags and the write pointer
- cfg_we  in  1  config write strobe
- cfg_delay  in  $clog2(DEPTH)+1  requested delay
- cfg_err  out  1  one-cycle pulse: cfg_delay rejected
- delay  out  $clog2(DEPTH)+1  current delay
- q  out  BITS  sample written exactly `delay` enables ago
- q_valid  out  1  valid tag of q
- occ  out  $clog2(DEPTH)+1  valid samples in the window; present only with PDL_OCC_EN

## Operation
- Storage:
  - mem[DEPTH] of BITS and vld[DEPTH] of 1 bit;
  - wptr is $clog2(DEPTH) bits and wraps naturally.
- Read pointer: rptr = (wptr − delay) mod DEPTH, computed combinationally.
  - q = mem[rptr], q_valid = vld[rptr]; both combinational from registers.
- en (no higher-priority event): mem[wptr]←d, vld[wptr]←d_valid, wptr←wptr+1.
  - With delay=DEPTH, rptr=wptr. The old entry is read on q before being overwritten at the edge.
- flush: all vld←0, wptr←0.
  - mem contents are retained, so q may be nonzero while q_valid=0.
- cfg_we with 1 ≤ cfg_delay ≤ DEPTH: delay←cfg_delay, plus an implicit flush.
- cfg_we with cfg_delay = 0 or cfg_delay > DEPTH:
  - delay unchanged, no flush;
  - cfg_err=1 on the next cycle;
  - the en sample in the same cycle is still written.
- Priority, per cycle:
  1. rst_n low
  2. flush
  3. valid cfg_we
  4. en
- A sample presented with en in the same cycle as flush or a valid cfg_we is dropped.
- After a flush or reconfig, q_valid stays 0 until `delay` enables with d_valid=1 have occurred.
- No FSM: the only state is pointers, tags and the delay register.

## Timing
- Reset values (first edge with rst_n=0):
  - mem all 0, vld all 0, wptr 0, delay=DEF_DELAY;
  - q=0, q_valid=0, cfg_err=0, occ=0.
- Reset mid-stream discards all data; no partial state survives.
- Latency: a sample written at en #k is on q during the cycle after en #(k+delay−1)'s edge.
  - It is visible until the next en edge.
  - Latency is counted in enables, not cycles; en=0 freezes q.
- Config and flush take effect at the edge; q/q_valid reflect the new rptr in the following cycle.
- cfg_err is registered, exactly one cycle wide per rejected write.

## Configuration
- Macro PDL_OCC_EN.
- Defined:
  - occ port and counter exist;
  - on en, occ ← occ + d_valid − q_valid;
  - flush or valid cfg_we → 0;
  - bounded to 0..delay by construction; no saturation logic.
- Undefined: occ port, counter and adder are absent; all other behaviour is identical.

## Structure
- Shared package pdl_pkg holds:
  - the pointer-width function and the delay-width function ($clog2(DEPTH)+1);
  - the cfg range-check function used by the MMIO decoder and this block.
- No sub-module: the block is a single module. Storage is a plain register array so the reset-to-zero requirement holds.

## Test plan
- Reset: DEPTH=8, BITS=64, DEF_DELAY=8.
  - Hold rst_n low 2 cycles → q=0, q_valid=0, delay=8, cfg_err=0.
- Full-depth delay: en continuously with d=1,2,3…, d_valid=1.
  - q_valid first 1 after the 8th en edge, with q=1.
  - Then q increments by 1 each cycle.
  - occ reads 8 in steady state (PDL_OCC_EN).
- Reprogram: cfg_delay=3 with cfg_we.
  - q_valid drops to 0.
  - Stream d=0x10… → q=0x10 after the 3rd en edge.
  - Idle cycles with en=0 hold q constant.
- Illegal config: cfg_delay=0, then cfg_delay=9.
  - Each gives cfg_err high for one cycle.
  - delay stays 3; the stream continues uninterrupted.
- Priority: flush and en (d=0xAA) in the same cycle.
  - 0xAA never appears on q with q_valid=1.
  - wptr=0; occ=0.
- Mid-stream reset: after 5 enables, pulse rst_n low for one cycle.
  - All outputs return to reset values; delay=DEF_DELAY.
  - No pre-reset sample ever emerges with q_valid=1.

Source files
------------

// File: rtl/pdl_pkg.sv
// Shared helpers for prog_delay_line and the MMIO decoder that programs it:
// pointer/delay widths and the legal-delay range check.
package pdl_pkg;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // One extra bit so the delay field can hold DEPTH itself.
    function automatic int dly_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic cfg_ok(input int val, input int depth);
        return (val >= 1) && (val <= depth);
    endfunction

endpackage

// File: rtl/prog_delay_line.sv
// Runtime-programmable circular delay line with per-entry valid tags and flush.
// Optional occupancy counter/port enabled by defining PDL_OCC_EN.
module prog_delay_line
    import pdl_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int BITS      = 64,
    parameter int DEF_DELAY = DEPTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [BITS-1:0]           d,
    input  logic                      d_valid,
    input  logic                      flush,
    input  logic                      cfg_we,
    input  logic [dly_w(DEPTH)-1:0]   cfg_delay,
    output logic                      cfg_err,
    output logic [dly_w(DEPTH)-1:0]   delay,
    output logic [BITS-1:0]           q,
    output logic                      q_valid
`ifdef PDL_OCC_EN
    ,
    output logic [dly_w(DEPTH)-1:0]   occ
`endif
);

    localparam int PW = ptr_w(DEPTH);
    localparam int DW = dly_w(DEPTH);

    logic [BITS-1:0]  r_mem [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PW-1:0]    r_wptr;
    logic [DW-1:0]    r_delay;
    logic             r_cfg_err;

    logic [PW-1:0]    w_rptr;
    logic             w_cfg_ok;
    logic             w_cfg_bad;
    logic             w_clear;

    // Power-of-two depth makes the modulo a plain truncating subtract;
    // delay == DEPTH truncates to 0 so the read lands on the write slot.
    assign w_rptr    = r_wptr - r_delay[PW-1:0];
    assign w_cfg_ok  = cfg_we && cfg_ok(32'(cfg_delay), DEPTH);
    assign w_cfg_bad = cfg_we && !cfg_ok(32'(cfg_delay), DEPTH);
    assign w_clear   = flush || w_cfg_ok;

    assign q       = r_mem[w_rptr];
    assign q_valid = r_vld[w_rptr];
    assign delay   = r_delay;
    assign cfg_err = r_cfg_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_vld     <= '0;
            r_wptr    <= '0;
            r_delay   <= DW'(DEF_DELAY);
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= w_cfg_bad;
            if (flush) begin
                r_vld  <= '0;
                r_wptr <= '0;
            end else if (w_cfg_ok) begin
                r_delay <= cfg_delay;
                r_vld   <= '0;
                r_wptr  <= '0;
            end else if (en) begin
                r_mem[r_wptr] <= d;
                r_vld[r_wptr] <= d_valid;
                r_wptr        <= r_wptr + 1'b1;
            end
        end
    end

`ifdef PDL_OCC_EN
    logic [DW-1:0] r_occ;

    // Entry leaving the window is the one on q; it stays within 0..delay.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_occ <= '0;
        end else if (w_clear) begin
            r_occ <= '0;
        end else if (en) begin
            r_occ <= r_occ + DW'(d_valid) - DW'(q_valid);
        end
    end

    assign occ = r_occ;
`endif

endmodule

// File: tb/tb_prog_delay_line.sv
// Directed self-checking bench for prog_delay_line (DEPTH=8, BITS=64, DEF_DELAY=8).
module tb_prog_delay_line;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [63:0] d;
    logic        d_valid;
    logic        flush;
    logic        cfg_we;
    logic [3:0]  cfg_delay;
    logic        cfg_err;
    logic [3:0]  delay;
    logic [63:0] q;
    logic        q_valid;
`ifdef PDL_OCC_EN
    logic [3:0]  occ;
`endif

    int checks = 0;
    int failures = 0;

    prog_delay_line #(.DEPTH(8), .BITS(64), .DEF_DELAY(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .d         (d),
        .d_valid   (d_valid),
        .flush     (flush),
        .cfg_we    (cfg_we),
        .cfg_delay (cfg_delay),
        .cfg_err   (cfg_err),
        .delay     (delay),
        .q         (q),
        .q_valid   (q_valid)
`ifdef PDL_OCC_EN
        ,
        .occ       (occ)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en = 1'b0; d = '0; d_valid = 1'b0; flush = 1'b0; cfg_we = 1'b0; cfg_delay = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        step();
        step();
        checks++; if (q !== 64'd0) begin failures++; $display("FAIL reset_q got=%0h exp=0", q); end
        checks++; if (q_valid !== 1'b0) begin failures++; $display("FAIL reset_qv got=%b exp=0", q_valid); end
        checks++; if (delay !== 4'd8) begin failures++; $display("FAIL reset_delay got=%0d exp=8", delay); end
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); end
`ifdef PDL_OCC_EN
        checks++; if (occ !== 4'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", occ); end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_full_depth();
        en = 1'b1; d_valid = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            d = 64'(k);
            step();
            if (k < 8) begin
                checks++; if (q_valid !== 1'b0) begin failures++; $display("FAIL full_early_qv k=%0d got=%b exp=0", k, q_valid); end
            end else begin
                checks++; if (q_valid !== 1'b1 || q !== 64'(k - 7)) begin
                    failures++; $display("FAIL full_q k=%0d got=%0h/%b exp=%0h/1", k, q, q_valid, k - 7);
                end
`ifdef PDL_OCC_EN
                checks++; if (occ !== 4'd8) begin failures++; $display("FAIL full_occ k=%0d got=%0d exp=8", k, occ); end
`endif
            end
        end
        idle_inputs();
    endtask

    task automatic test_reprogram();
        cfg_we = 1'b1; cfg_delay = 4'd3;
        step();
        cfg_we = 1'b0;
        checks++; if (delay !== 4'd3) begin failures++; $display("FAIL reprog_delay got=%0d exp=3", delay); end
        checks++; if (q_valid !== 1'b0) begin failures++; $display("FAIL reprog_qv got=%b exp=0", q_valid); end
`ifdef PDL_OCC_EN
        checks++; if (occ !== 4'd0) begin failures++; $display("FAIL reprog_occ got=%0d exp=0", occ); end
`endif
        en = 1'b1; d_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            d = 64'h10 + 64'(k);
            step();
            if (k < 2) begin
                checks++; if (q_valid !== 1'b0) begin failures++; $display("FAIL reprog_early_qv k=%0d got=%b exp=0", k, q_valid); end
            end
        end
        checks++; if (q !== 64'h10 || q_valid !== 1'b1) begin failures++; $display("FAIL reprog_first got=%0h/%b exp=10/1", q, q_valid); end
        en = 1'b0; d = 64'hDEAD;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (q !== 64'h10 || q_valid !== 1'b1) begin failures++; $display("FAIL hold_q k=%0d got=%0h/%b exp=10/1", k, q, q_valid); end
        end
        en = 1'b1; d = 64'h13;
        step();
        checks++; if (q !== 64'h11 || q_valid !== 1'b1) begin failures++; $display("FAIL resume_q got=%0h/%b exp=11/1", q, q_valid); end
    endtask

    task automatic test_illegal_cfg();
        logic [3:0] bad [2];
        bad[0] = 4'd0; bad[1] = 4'd9;
        en = 1'b1; d_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cfg_we = 1'b1; cfg_delay = bad[i]; d = 64'h14 + 64'(2 * i);
            step();
            checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL illegal_err_hi i=%0d got=%b exp=1", i, cfg_err); end
            checks++; if (delay !== 4'd3) begin failures++; $display("FAIL illegal_delay i=%0d got=%0d exp=3", i, delay); end
            checks++; if (q !== 64'h12 + 64'(2 * i) || q_valid !== 1'b1) begin
                failures++; $display("FAIL illegal_q i=%0d got=%0h/%b exp=%0h/1", i, q, q_valid, 18 + 2 * i);
            end
            cfg_we = 1'b0; d = 64'h15 + 64'(2 * i);
            step();
            checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL illegal_err_lo i=%0d got=%b exp=0", i, cfg_err); end
            checks++; if (q !== 64'h13 + 64'(2 * i) || q_valid !== 1'b1) begin
                failures++; $display("FAIL illegal_q2 i=%0d got=%0h/%b exp=%0h/1", i, q, q_valid, 19 + 2 * i);
            end
        end
        idle_inputs();
    endtask

    task automatic test_priority();
        flush = 1'b1; en = 1'b1; d = 64'hAA; d_valid = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (q_valid !== 1'b0) begin failures++; $display("FAIL prio_qv got=%b exp=0", q_valid); end
`ifdef PDL_OCC_EN
        checks++; if (occ !== 4'd0) begin failures++; $display("FAIL prio_occ got=%0d exp=0", occ); end
`endif
        for (int k = 0; k < 8; k++) begin
            d = 64'h20 + 64'(k);
            step();
            checks++; if (q_valid === 1'b1 && q === 64'hAA) begin failures++; $display("FAIL prio_aa k=%0d got=%0h exp=not_aa", k, q); end
            if (k >= 2) begin
                checks++; if (q !== 64'h1E + 64'(k) || q_valid !== 1'b1) begin
                    failures++; $display("FAIL prio_q k=%0d got=%0h/%b exp=%0h/1", k, q, q_valid, 30 + k);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_mid_reset();
        en = 1'b1; d_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            d = 64'h50 + 64'(k);
            step();
        end
        rst_n = 1'b0; en = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (q !== 64'd0 || q_valid !== 1'b0) begin failures++; $display("FAIL mrst_q got=%0h/%b exp=0/0", q, q_valid); end
        checks++; if (delay !== 4'd8) begin failures++; $display("FAIL mrst_delay got=%0d exp=8", delay); end
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL mrst_cfg_err got=%b exp=0", cfg_err); end
`ifdef PDL_OCC_EN
        checks++; if (occ !== 4'd0) begin failures++; $display("FAIL mrst_occ got=%0d exp=0", occ); end
`endif
        en = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            d = 64'h2F + 64'(k);
            d_valid = (k != 9);
            step();
            if (k < 8) begin
                checks++; if (q_valid !== 1'b0) begin failures++; $display("FAIL mrst_stale k=%0d got=%0h/%b exp=x/0", k, q, q_valid); end
            end else begin
                checks++; if (q !== 64'h28 + 64'(k) || q_valid !== (k != 16)) begin
                    failures++; $display("FAIL mrst_q k=%0d got=%0h/%b exp=%0h/%b", k, q, q_valid, 40 + k, k != 16);
                end
            end
        end
`ifdef PDL_OCC_EN
        checks++; if (occ !== 4'd7) begin failures++; $display("FAIL mrst_occ_tag got=%0d exp=7", occ); end
`endif
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_full_depth();
        test_reprogram();
        test_illegal_cfg();
        test_priority();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
